// File: rtl/apb_regfile_bridge.sv
// APB3 slave bridge in front of the regfile: decode, RO protection,
// wait states, PSLVERR, single-cycle regfile strobe.
//
// Ports:
//   ACLK, ARSTn       clock, synchronous active-low reset
//   PSEL..PWDATA      APB3 request inputs
//   PRDATA, PREADY    APB3 response (valid in DONE only)
//   PSLVERR           APB3 error, qualified by PREADY
//   addr_in, data_in  regfile word index / write data (held)
//   rw                regfile write strobe, one cycle per write
//   data_out          regfile read data (combinational on addr_in)
module apb_regfile_bridge #(
  parameter int                  NUM_REGS    = 3,
  parameter int                  WAIT_CYCLES = 1,
  parameter logic [NUM_REGS-1:0] RO_MASK     = 3'b100
) (
  input  logic        ACLK,
  input  logic        ARSTn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] addr_in,
  output logic [31:0] data_in,
  output logic        rw,
  input  logic [31:0] data_out
);

  localparam int CW =
    (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_COMMIT,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic [31:0]   prdata_q;
  logic          wr_q;
  logic          err_q;
  logic          rw_q;
  logic          pready_q;
  logic          pslverr_q;

  logic [29:0]   idx;
  logic          ro_hit;
  logic          setup;
  logic          setup_err;

  assign idx   = PADDR[31:2];
  assign setup = PSEL & ~PENABLE;

  // Guarded lookup so an out-of-range index never
  // indexes past the end of RO_MASK.
  always_comb begin
    ro_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == 30'(i)) ro_hit = RO_MASK[i];
    end
  end

  assign setup_err = (PADDR[1:0] != 2'b00)
                   | (idx >= 30'(NUM_REGS))
                   | (PWRITE & ro_hit);

  always_ff @(posedge ACLK) begin
    if (!ARSTn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      prdata_q  <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      rw_q      <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          rw_q      <= 1'b0;
          if (setup) begin
            addr_q <= {2'b00, idx};
            data_q <= PWDATA;
            wr_q   <= PWRITE;
            err_q  <= setup_err;
            cnt_q  <= CW'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state_q <= S_COMMIT;
              rw_q    <= PWRITE & ~setup_err;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!PSEL) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              state_q <= S_COMMIT;
              rw_q    <= wr_q & ~err_q;
            end
          end
        end
        S_COMMIT: begin
          rw_q <= 1'b0;
          if (!PSEL) begin
            state_q <= S_IDLE;
          end else begin
            state_q   <= S_DONE;
            pready_q  <= 1'b1;
            pslverr_q <= err_q;
            prdata_q  <= (!wr_q && !err_q) ? data_out : '0;
          end
        end
        S_DONE: begin
          state_q   <= S_IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // PSEL gating lets a master abort during COMMIT
  // without the regfile seeing the write.
  assign rw      = rw_q & PSEL;
  assign addr_in = addr_q;
  assign data_in = data_q;
  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: doc/apb_regfile_bridge.md
Name: apb_regfile_bridge

Overview:
APB3 slave front-end that sits directly upstream of the regfile block. It converts APB transfers into single-cycle regfile accesses on addr_in/data_in/rw, and returns regfile data_out on PRDATA. It adds address decode, read-only protection, configurable wait states and PSLVERR reporting.

Parameters:
NUM_REGS, 3, number of regfile words; valid word index range is 0..NUM_REGS-1.
WAIT_CYCLES, 1, extra wait states inserted before commit (0 allowed).
RO_MASK, 'b100 (NUM_REGS bits), bit i=1 makes word i read-only from APB (r2 holds the adder result).

Ports:
ACLK  in  1  clock; all logic on posedge.
ARSTn  in  1  reset, synchronous, active-low.
PSEL  in  1  APB select.
PENABLE  in  1  APB access phase.
PWRITE  in  1  1=write, 0=read.
PADDR  in  32  APB byte address.
PWDATA  in  32  APB write data.
PRDATA  out  32  APB read data.
PREADY  out  1  transfer complete.
PSLVERR  out  1  transfer error, valid only with PREADY.
addr_in  out  32  regfile word index, zero-extended.
data_in  out  32  regfile write data.
rw  out  1  regfile strobe (0=read, 1=write); high for exactly one cycle per committed write.
data_out  in  32  regfile read data, combinational from addr_in.

Behaviour:
- Reset (ARSTn=0 at posedge): state=IDLE; counter=0; addr_in=0; data_in=0; rw=0; PRDATA=0; PREADY=0; PSLVERR=0. Reset overrides any in-flight transfer; no write is issued.
- Decode at setup: idx=PADDR[31:2]. err = PADDR[1:0]!=0 OR idx>=NUM_REGS OR (PWRITE AND RO_MASK[idx]).
- FSM states: IDLE, WAIT, COMMIT, DONE.
- IDLE: when PSEL=1 and PENABLE=0, latch idx into addr_in, PWDATA into data_in, PWRITE, and err. Load counter=WAIT_CYCLES. Go to WAIT, or to COMMIT if WAIT_CYCLES=0.
- WAIT: decrement counter; go to COMMIT when counter reaches 1 (i.e. after WAIT_CYCLES cycles).
- COMMIT: rw = write AND NOT err AND PSEL, for this cycle only. On a read with no error, capture data_out into PRDATA at the end of the cycle. Go to DONE.
- DONE: PREADY=1; PSLVERR=err; PRDATA = captured data on a valid read, else 0. Next state is IDLE unconditionally.
- Outside DONE: PREADY=0, PSLVERR=0, PRDATA=0.
- Latency: setup cycle c0, WAIT c1..cW, COMMIT cW+1, DONE cW+2. Total W+3 cycles per transfer (4 at default).
- Back-to-back: a setup phase in the cycle right after DONE is accepted by IDLE; no dead cycle.
- Errors: an erroneous transfer never asserts rw and still completes normally with PSLVERR=1.
- Abort: PSEL sampled 0 in WAIT or COMMIT returns the FSM to IDLE next cycle. rw is suppressed, PREADY is never asserted and regfile state is unchanged.
- PENABLE is not checked after setup; the protocol timing is owned by the master.
- addr_in and data_in hold their last latched values between transfers.

Test Plan:
1. Reset: assert ARSTn=0 for 2 cycles during WAIT of a write -> all outputs 0, no rw pulse, FSM accepts the next setup normally.
2. Write: PADDR=0x4, PWDATA=0xDEADBEEF, WAIT_CYCLES=1 -> rw=1 only in cycle 2 with addr_in=1, data_in=0xDEADBEEF. PREADY=1 in cycle 3, PSLVERR=0; regfile r1=0xDEADBEEF.
3. Read: PADDR=0x4 after test 2 -> PRDATA=0xDEADBEEF with PREADY=1, PSLVERR=0; rw stays 0 throughout.
4. Errors: write 0x8 (read-only), write 0xC (out of range), write 0x5 (misaligned) -> PSLVERR=1 with PREADY, rw never 1, r2 unchanged. Read 0xC -> PRDATA=0, PSLVERR=1.
5. Back-to-back: write 0x0=0x11111111, then write 0x4=0x22222222 with setup in the cycle after DONE -> two rw pulses 4 cycles apart; r0=0x11111111, r1=0x22222222.
6. Abort and WAIT_CYCLES=0: drop PSEL in WAIT -> no rw, no PREADY, FSM in IDLE. With WAIT_CYCLES=0 a write completes in 3 cycles, with PREADY in cycle 2.
